// File: rtl/store_buffer_defines.sv
// Project-wide field ranges shared by the store-buffer RTL.
`ifndef STORE_BUFFER_DEFINES_SV
`define STORE_BUFFER_DEFINES_SV

`define WORD_ADDR 31:2

`endif

// File: rtl/store_buffer_match.sv
// DEPTH-way word-address comparator with a youngest-first priority select.
`include "store_buffer_defines.sv"

module sb_match #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic [29:0]   entry_addr [DEPTH],
    input  logic [29:0]   ld_waddr,
    input  logic [PW-1:0] wr_ptr,
    input  logic [CW-1:0] count,
    output logic          hit,
    output logic [PW-1:0] index
);

    // Slot gi holds the entry that is gi positions older than the youngest.
    logic [PW-1:0] slot_idx [DEPTH];
    logic [DEPTH-1:0] match_age;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign slot_idx[gi]  = wr_ptr - PW'(gi + 1);
            assign match_age[gi] = (CW'(gi) < count) &&
                                   (entry_addr[slot_idx[gi]] == ld_waddr);
        end
    endgenerate

    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_age[k]) begin
                hit   = 1'b1;
                index = slot_idx[k];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write queue feeding the data memory's single write port, with
// same-word coalescing into the youngest entry and load forwarding.
`include "store_buffer_defines.sv"

module store_buffer #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [31:0]   st_pc,
    input  logic [31:0]   ld_addr,
    output logic          ld_hit,
    output logic [31:0]   ld_data,
    input  logic          dm_busy,
    output logic          dm_we,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [31:0]   dm_pc,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] youngest;
    logic [PW-1:0] wr_idx;
    logic          accept;
    logic          coalesce;
    logic          alloc;
    logic          fwd_hit;
    logic [PW-1:0] fwd_idx;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign st_ready = !full;
    assign dm_we    = !empty && !dm_busy;

    assign dm_addr  = {addr_q[rd_ptr_q], 2'b00};
    assign dm_wdata = data_q[rd_ptr_q];
    assign dm_pc    = pc_q[rd_ptr_q];

    assign youngest = wr_ptr_q - PW'(1);
    assign accept   = st_valid && st_ready;
    // The youngest entry cannot absorb a store on the edge it leaves the queue.
    assign coalesce = accept && !empty &&
                      (addr_q[youngest] == st_addr[`WORD_ADDR]) &&
                      !(dm_we && (youngest == rd_ptr_q));
    assign alloc    = accept && !coalesce;
    assign wr_idx   = coalesce ? youngest : wr_ptr_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(alloc) - CW'(dm_we);
        if (dm_we) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (alloc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payloads carry no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (alloc || coalesce) begin
            addr_q[wr_idx] <= st_addr[`WORD_ADDR];
            data_q[wr_idx] <= st_data;
            pc_q[wr_idx]   <= st_pc;
        end
    end

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entry_addr (addr_q),
        .ld_waddr   (ld_addr[`WORD_ADDR]),
        .wr_ptr     (wr_ptr_q),
        .count      (count_q),
        .hit        (fwd_hit),
        .index      (fwd_idx)
    );

    assign ld_hit  = fwd_hit;
    assign ld_data = fwd_hit ? data_q[fwd_idx] : 32'h0;

endmodule
